pifo_port_arbiter: RTL and testbench

Shares one egress AXI4-Stream port between NUM_QUEUES PIFO output queues. At each packet boundary it grants the head packet with the smallest root rank (`tpifo`), with an age-based anti-starvation override. The grant is held until that packet's `tlast` beat completes. It sits between the per-class output queue instances and the port MAC/egress FIFO.

---
 rtl/pifo_pkg.sv | 31 +++
 rtl/pifo_min_select.sv | 34 +++
 rtl/pifo_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_pifo_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_pkg.sv
// Shared PIFO descriptor layout, sort-key helper and arbiter state type.
// Pure declarations: no logic, no latency, no flow control.
package pifo_pkg;

    localparam int PIFO_VALID_BIT = 31;
    localparam int RANK_MSB       = 30;
    localparam int RANK_LSB       = 12;
    localparam int RANK_WIDTH     = RANK_MSB - RANK_LSB + 1;
    localparam int DESC_WIDTH     = 32;
    localparam int KEY_WIDTH      = RANK_WIDTH + 1;
    localparam int AGE_WIDTH      = 8;

    typedef struct packed {
        logic                  vld;
        logic [RANK_WIDTH-1:0] rank;
        logic [11:0]           rsvd;
    } pifo_desc_t;

    typedef logic [KEY_WIDTH-1:0] rank_key_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

    // Inverting the valid bit pushes descriptor-less heads behind every real rank.
    function automatic rank_key_t rank_key(input pifo_desc_t desc);
        return {~desc.vld, desc.rank};
    endfunction

endpackage

// File: rtl/pifo_min_select.sv
// Combinational lowest-key picker over N masked keys; equal keys resolve in
// round-robin order from start_idx. Zero latency, no flow control.
module pifo_min_select #(
    parameter  int N  = 4,
    parameter  int KW = 20,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0][KW-1:0] key,
    input  logic [N-1:0]         mask,
    input  logic [IW-1:0]        start_idx,
    output logic [IW-1:0]        win_idx,
    output logic                 win_vld
);

    logic [KW-1:0] best_key;
    int            idx;

    // Scanning from start_idx with a strict compare lets the first equal key win.
    always_comb begin
        win_idx  = '0;
        win_vld  = 1'b0;
        best_key = '0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(start_idx) + i) % N;
            if (mask[idx] && (!win_vld || (key[idx] < best_key))) begin
                win_vld  = 1'b1;
                best_key = key[idx];
                win_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/pifo_port_arbiter.sv
// Packet-boundary arbiter sharing one AXI4-Stream egress among PIFO queues by min rank with age override.
// One decision cycle per packet, then a combinational pass-through; m_axis_tready feeds only the granted queue.
module pifo_port_arbiter
    import pifo_pkg::*;
#(
    parameter  int NUM_QUEUES = 4,
    parameter  int DATA_WIDTH = 256,
    parameter  int USER_WIDTH = 128,
    parameter  int AGE_LIMIT  = 16,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int IDX_WIDTH  = $clog2(NUM_QUEUES)
) (
    input  logic                             axis_aclk,
    input  logic                             axis_resetn,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_QUEUES*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_QUEUES*USER_WIDTH-1:0] s_axis_tuser,
    input  logic [NUM_QUEUES*DESC_WIDTH-1:0] s_axis_tpifo,
    input  logic [NUM_QUEUES-1:0]            s_axis_tvalid,
    input  logic [NUM_QUEUES-1:0]            s_axis_tlast,
    output logic [NUM_QUEUES-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic [DESC_WIDTH-1:0]            m_axis_tpifo,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready,
    output logic [IDX_WIDTH-1:0]             grant_idx,
    output logic                             grant_active
);

    arb_state_t                               state_q, state_d;
    logic [IDX_WIDTH-1:0]                     grant_idx_q, grant_idx_d;
    logic [NUM_QUEUES-1:0][AGE_WIDTH-1:0]     age_q, age_d;

    logic [NUM_QUEUES-1:0][KEY_WIDTH-1:0]     rank_keys;
    logic [NUM_QUEUES-1:0][AGE_WIDTH-1:0]     age_keys;
    logic [NUM_QUEUES-1:0]                    age_hit;
    logic [IDX_WIDTH-1:0]                     start_idx;
    logic [IDX_WIDTH-1:0]                     rank_win_idx, age_win_idx, win_idx;
    logic                                     rank_win_vld, age_win_vld;
    logic                                     age_override;
    logic                                     xfer;
    int                                       gsel;

    always_comb begin
        rank_keys = '0;
        age_keys  = '0;
        age_hit   = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            rank_keys[i] = rank_key(pifo_desc_t'(s_axis_tpifo[i*DESC_WIDTH +: DESC_WIDTH]));
            // Inverted age turns the min picker into a max picker.
            age_keys[i]  = ~age_q[i];
            age_hit[i]   = s_axis_tvalid[i] && (age_q[i] >= AGE_WIDTH'(AGE_LIMIT));
        end
    end

    assign start_idx = (grant_idx_q == IDX_WIDTH'(NUM_QUEUES - 1)) ? '0 : grant_idx_q + 1'b1;

    pifo_min_select #(
        .N  (NUM_QUEUES),
        .KW (KEY_WIDTH)
    ) u_rank_sel (
        .key       (rank_keys),
        .mask      (s_axis_tvalid),
        .start_idx (start_idx),
        .win_idx   (rank_win_idx),
        .win_vld   (rank_win_vld)
    );

    pifo_min_select #(
        .N  (NUM_QUEUES),
        .KW (AGE_WIDTH)
    ) u_age_sel (
        .key       (age_keys),
        .mask      (s_axis_tvalid),
        .start_idx (start_idx),
        .win_idx   (age_win_idx),
        .win_vld   (age_win_vld)
    );

    assign age_override = age_win_vld && (|age_hit);
    assign win_idx      = age_override ? age_win_idx : rank_win_idx;

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        age_d       = age_q;
        case (state_q)
            ST_IDLE: begin
                if (rank_win_vld) begin
                    state_d     = ST_XFER;
                    grant_idx_d = win_idx;
                    for (int i = 0; i < NUM_QUEUES; i++) begin
                        if (s_axis_tvalid[i]) begin
                            if (IDX_WIDTH'(i) == win_idx) begin
                                age_d[i] = '0;
                            end else if (age_q[i] != '1) begin
                                age_d[i] = age_q[i] + 8'd1;
                            end
                        end
                    end
                end
            end
            ST_XFER: begin
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            age_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            age_q       <= age_d;
        end
    end

    assign xfer = (state_q == ST_XFER);
    assign gsel = int'(grant_idx_q);

    // Outputs are gated by state so nothing is consumed or presented outside a grant.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tpifo  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (xfer) begin
            m_axis_tdata        = s_axis_tdata[gsel*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tkeep        = s_axis_tkeep[gsel*KEEP_WIDTH +: KEEP_WIDTH];
            m_axis_tuser        = s_axis_tuser[gsel*USER_WIDTH +: USER_WIDTH];
            m_axis_tpifo        = s_axis_tpifo[gsel*DESC_WIDTH +: DESC_WIDTH];
            m_axis_tvalid       = s_axis_tvalid[grant_idx_q];
            m_axis_tlast        = s_axis_tlast[grant_idx_q];
            s_axis_tready[grant_idx_q] = m_axis_tready;
        end
    end

    assign grant_idx    = grant_idx_q;
    assign grant_active = xfer;

endmodule

// File: tb/tb_pifo_port_arbiter.sv
// Directed-vector bench for pifo_port_arbiter: per-queue beat sources, a
// recording sink, and hand-computed expected orders and cycle positions.
module tb_pifo_port_arbiter;

    localparam int NQ = 4;
    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = DW / 8;

    logic              axis_aclk;
    logic              axis_resetn;
    logic [NQ*DW-1:0]  s_axis_tdata;
    logic [NQ*KW-1:0]  s_axis_tkeep;
    logic [NQ*UW-1:0]  s_axis_tuser;
    logic [NQ*32-1:0]  s_axis_tpifo;
    logic [NQ-1:0]     s_axis_tvalid;
    logic [NQ-1:0]     s_axis_tlast;
    logic [NQ-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [UW-1:0]     m_axis_tuser;
    logic [31:0]       m_axis_tpifo;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [1:0]        grant_idx;
    logic              grant_active;

    pifo_port_arbiter #(
        .NUM_QUEUES (NQ),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .AGE_LIMIT  (4)
    ) dut (
        .axis_aclk     (axis_aclk),
        .axis_resetn   (axis_resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tpifo  (s_axis_tpifo),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tpifo  (m_axis_tpifo),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .grant_idx     (grant_idx),
        .grant_active  (grant_active)
    );

    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mem_dat  [NQ][64];
    logic        mem_last [NQ][64];
    logic [31:0] mem_pifo [NQ][64];
    int          rd [NQ];
    int          wr [NQ];

    logic [31:0] out_dat  [64];
    logic [31:0] out_user [64];
    logic        out_last [64];
    int          out_cyc  [64];
    int          nout;
    int          gseq [64];
    int          ng;
    int          viol;
    logic        prev_ga;
    int          cyc;
    logic        ga_hist [2048];
    logic [1:0]  gi_hist [2048];
    int          s;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] desc(input logic v, input int rank);
        return {v, 19'(rank), 12'h000};
    endfunction

    task automatic drive_inputs();
        for (int q = 0; q < NQ; q++) begin
            if (rd[q] < wr[q]) begin
                s_axis_tvalid[q]        = 1'b1;
                s_axis_tlast[q]         = mem_last[q][rd[q]];
                s_axis_tdata[q*DW +: DW] = DW'(mem_dat[q][rd[q]]);
                s_axis_tpifo[q*32 +: 32] = mem_pifo[q][rd[q]];
                s_axis_tkeep[q*KW +: KW] = '1;
                s_axis_tuser[q*UW +: UW] = UW'(q + 8'hA0);
            end else begin
                s_axis_tvalid[q]        = 1'b0;
                s_axis_tlast[q]         = 1'b0;
                s_axis_tdata[q*DW +: DW] = '0;
                s_axis_tpifo[q*32 +: 32] = '0;
                s_axis_tkeep[q*KW +: KW] = '0;
                s_axis_tuser[q*UW +: UW] = '0;
            end
        end
    endtask

    task automatic pkt(input int q, input int n, input logic [31:0] base, input logic [31:0] pifo);
        for (int k = 0; k < n; k++) begin
            mem_dat[q][wr[q]]  = base + 32'(k);
            mem_last[q][wr[q]] = (k == n - 1);
            mem_pifo[q][wr[q]] = pifo;
            wr[q]++;
        end
        drive_inputs();
    endtask

    task automatic clear();
        nout = 0;
        ng   = 0;
        viol = 0;
    endtask

    // One clock: observe at the falling edge, advance sources just after the rising edge.
    task automatic step(input logic rdy);
        logic [NQ-1:0] fire;
        logic          exp_r;
        m_axis_tready = rdy;
        @(negedge axis_aclk);
        ga_hist[cyc] = grant_active;
        gi_hist[cyc] = grant_idx;
        for (int q = 0; q < NQ; q++) begin
            exp_r = (grant_active && (int'(grant_idx) == q)) ? rdy : 1'b0;
            if (s_axis_tready[q] !== exp_r) viol++;
            fire[q] = s_axis_tvalid[q] & s_axis_tready[q];
        end
        if (!grant_active && (m_axis_tvalid !== 1'b0)) viol++;
        if (m_axis_tvalid && m_axis_tready) begin
            out_dat[nout]  = m_axis_tdata[31:0];
            out_user[nout] = m_axis_tuser[31:0];
            out_last[nout] = m_axis_tlast;
            out_cyc[nout]  = cyc;
            nout++;
        end
        if (grant_active && !prev_ga) begin
            gseq[ng] = int'(grant_idx);
            ng++;
        end
        prev_ga = grant_active;
        @(posedge axis_aclk);
        #1;
        for (int q = 0; q < NQ; q++) if (fire[q]) rd[q]++;
        cyc++;
        drive_inputs();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b1);
    endtask

    initial begin
        axis_resetn   = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tpifo  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        for (int q = 0; q < NQ; q++) begin
            rd[q] = 0;
            wr[q] = 0;
        end
        prev_ga = 1'b0;
        cyc     = 0;
        clear();
        repeat (3) @(posedge axis_aclk);
        #1;

        chk("rst_m_tvalid",  32'(m_axis_tvalid), 32'd0);
        chk("rst_m_tlast",   32'(m_axis_tlast),  32'd0);
        chk("rst_s_tready",  32'(s_axis_tready), 32'd0);
        chk("rst_grant_idx", 32'(grant_idx),     32'd0);
        chk("rst_grant_act", 32'(grant_active),  32'd0);
        axis_resetn = 1'b1;
        run(2);

        // Single queue, 3 beats
        clear();
        s = cyc;
        pkt(0, 3, 32'h1a, desc(1'b1, 100));
        run(6);
        chk("single_count", 32'(nout), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("single_dat%0d", k), out_dat[k], 32'h1a + 32'(k));
            chk($sformatf("single_cyc%0d", k), 32'(out_cyc[k]), 32'(s + 1 + k));
        end
        chk("single_last", 32'(out_last[2]), 32'd1);
        chk("single_grant", 32'(gseq[0]), 32'd0);
        chk("single_tready_rules", 32'(viol), 32'd0);

        // Rank priority
        clear();
        s = cyc;
        pkt(0, 2, 32'h50a, desc(1'b1, 50));
        pkt(2, 2, 32'h10a, desc(1'b1, 10));
        run(8);
        chk("rank_count", 32'(nout), 32'd4);
        chk("rank_d0", out_dat[0], 32'h10a);
        chk("rank_d1", out_dat[1], 32'h10b);
        chk("rank_d2", out_dat[2], 32'h50a);
        chk("rank_d3", out_dat[3], 32'h50b);
        chk("rank_user0", out_user[0], 32'hA2);
        chk("rank_cyc2_bubble", 32'(out_cyc[2]), 32'(s + 4));
        chk("rank_g0", 32'(gseq[0]), 32'd2);
        chk("rank_g1", 32'(gseq[1]), 32'd0);
        chk("rank_tready_rules", 32'(viol), 32'd0);

        // Tie and invalid descriptor, last grant = 1
        clear();
        pkt(1, 1, 32'h11, desc(1'b1, 7));
        run(3);
        chk("tie_pre_grant", 32'(grant_idx), 32'd1);
        clear();
        pkt(1, 1, 32'h21, desc(1'b1, 200));
        pkt(3, 1, 32'h23, desc(1'b1, 200));
        pkt(0, 1, 32'h20, desc(1'b0, 0));
        run(10);
        chk("tie_count", 32'(nout), 32'd3);
        chk("tie_d0", out_dat[0], 32'h23);
        chk("tie_d1", out_dat[1], 32'h21);
        chk("tie_d2", out_dat[2], 32'h20);
        chk("tie_tready_rules", 32'(viol), 32'd0);

        // Backpressure: stall after the third beat for three cycles
        clear();
        s = cyc;
        pkt(0, 6, 32'h40, desc(1'b1, 20));
        step(1'b1);
        repeat (3) step(1'b1);
        repeat (3) step(1'b0);
        repeat (5) step(1'b1);
        chk("bp_count", 32'(nout), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("bp_dat%0d", k), out_dat[k], 32'h40 + 32'(k));
            chk($sformatf("bp_cyc%0d", k), 32'(out_cyc[k]), 32'((k < 3) ? (s + 1 + k) : (s + 4 + k)));
        end
        bad = 0;
        for (int c = s + 1; c <= s + 9; c++) if (!ga_hist[c] || (gi_hist[c] != 2'd0)) bad++;
        chk("bp_grant_held", 32'(bad), 32'd0);
        chk("bp_tready_track", 32'(viol), 32'd0);

        // Starvation with AGE_LIMIT = 4
        clear();
        for (int k = 0; k < 10; k++) pkt(0, 1, 32'h600 + 32'(k), desc(1'b1, 10));
        pkt(1, 1, 32'h700, desc(1'b1, 500));
        run(26);
        chk("starve_count", 32'(nout), 32'd11);
        for (int k = 0; k < 5; k++)
            chk($sformatf("starve_g%0d", k), 32'(gseq[k]), (k == 4) ? 32'd1 : 32'd0);
        chk("starve_d4", out_dat[4], 32'h700);
        chk("starve_age_q1", 32'(dut.age_q[1]), 32'd0);

        // Asynchronous reset during beat 2 of a 4-beat packet
        clear();
        pkt(3, 4, 32'h300, desc(1'b1, 9));
        step(1'b1);
        step(1'b1);
        chk("arst_pre_vld", 32'(m_axis_tvalid), 32'd1);
        chk("arst_pre_gidx", 32'(grant_idx), 32'd3);
        #2;
        axis_resetn = 1'b0;
        #1;
        chk("arst_m_tvalid",  32'(m_axis_tvalid), 32'd0);
        chk("arst_m_tlast",   32'(m_axis_tlast),  32'd0);
        chk("arst_s_tready",  32'(s_axis_tready), 32'd0);
        chk("arst_grant_idx", 32'(grant_idx),     32'd0);
        chk("arst_grant_act", 32'(grant_active),  32'd0);
        rd[3] = wr[3];
        drive_inputs();
        @(posedge axis_aclk);
        #1;
        axis_resetn = 1'b1;
        prev_ga = 1'b0;
        clear();
        s = cyc;
        pkt(2, 1, 32'h2222, desc(1'b1, 3));
        run(3);
        chk("post_rst_count", 32'(nout), 32'd1);
        chk("post_rst_dat", out_dat[0], 32'h2222);
        chk("post_rst_cyc", 32'(out_cyc[0]), 32'(s + 1));
        chk("post_rst_grant", 32'(gseq[0]), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
